// File: rtl/reservation_station_if.sv
// Issue, CDB, flush and dispatch signals shared by the issue stage,
// the reservation station and its functional unit.
interface reservation_station_if #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 8,
  parameter int OP_WIDTH  = 4
);
  logic                 issue_en;
  logic [OP_WIDTH-1:0]  issue_op;
  logic [XLEN-1:0]      issue_vj;
  logic [XLEN-1:0]      issue_vk;
  logic [TAG_WIDTH-1:0] issue_qj;
  logic [TAG_WIDTH-1:0] issue_qk;
  logic                 issue_qj_valid;
  logic                 issue_qk_valid;
  logic [TAG_WIDTH-1:0] issue_dest_tag;
  logic                 full;

  logic                 cdb_active;
  logic [XLEN-1:0]      cdb_data;
  logic [TAG_WIDTH-1:0] cdb_tag;

  logic                 flush;

  logic                 dispatch_valid;
  logic                 dispatch_ready;
  logic [OP_WIDTH-1:0]  dispatch_op;
  logic [XLEN-1:0]      dispatch_vj;
  logic [XLEN-1:0]      dispatch_vk;
  logic [TAG_WIDTH-1:0] dispatch_tag;

  // Driver side: issue stage, CDB, recovery logic and functional unit.
  modport master (
    output issue_en, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
           issue_qj_valid, issue_qk_valid, issue_dest_tag,
           cdb_active, cdb_data, cdb_tag, flush, dispatch_ready,
    input  full, dispatch_valid, dispatch_op, dispatch_vj, dispatch_vk,
           dispatch_tag
  );

  // Reservation station side.
  modport slave (
    input  issue_en, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
           issue_qj_valid, issue_qk_valid, issue_dest_tag,
           cdb_active, cdb_data, cdb_tag, flush, dispatch_ready,
    output full, dispatch_valid, dispatch_op, dispatch_vj, dispatch_vk,
           dispatch_tag
  );
endinterface

// File: rtl/reservation_station.sv
// Tomasulo reservation station: holds issued instructions until their
// operands arrive on the CDB, then dispatches the lowest-index ready entry.
module reservation_station #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 8,
  parameter int RS_SIZE   = 4,
  parameter int OP_WIDTH  = 4
) (
  input logic                   clk,
  input logic                   reset,
  reservation_station_if.slave  bus
);

  logic [RS_SIZE-1:0]   busy;
  logic [RS_SIZE-1:0]   qj_valid;
  logic [RS_SIZE-1:0]   qk_valid;
  logic [OP_WIDTH-1:0]  op_q   [RS_SIZE];
  logic [XLEN-1:0]      vj_q   [RS_SIZE];
  logic [XLEN-1:0]      vk_q   [RS_SIZE];
  logic [TAG_WIDTH-1:0] qj_q   [RS_SIZE];
  logic [TAG_WIDTH-1:0] qk_q   [RS_SIZE];
  logic [TAG_WIDTH-1:0] dest_q [RS_SIZE];

  logic [RS_SIZE-1:0]   ready;
  logic [RS_SIZE-1:0]   grant;
  logic [RS_SIZE-1:0]   free_oh;
  logic                 issue_fire;
  logic                 dispatch_fire;
  logic                 j_bypass;
  logic                 k_bypass;

  // Ready vector and one-hot lowest-index picks for dispatch and free slot.
  always_comb begin
    ready         = busy & ~qj_valid & ~qk_valid;
    grant         = ready & ~(ready - RS_SIZE'(1));
    free_oh       = ~busy & (busy + RS_SIZE'(1));
    issue_fire    = bus.issue_en && !(&busy);
    dispatch_fire = (|ready) && bus.dispatch_ready;
    j_bypass      = bus.issue_qj_valid && bus.cdb_active && (bus.issue_qj == bus.cdb_tag);
    k_bypass      = bus.issue_qk_valid && bus.cdb_active && (bus.issue_qk == bus.cdb_tag);
  end

  assign bus.full           = &busy;
  assign bus.dispatch_valid = |ready;

  // One-hot OR mux of the granted entry; all-zero when nothing is ready.
  always_comb begin
    bus.dispatch_op  = '0;
    bus.dispatch_vj  = '0;
    bus.dispatch_vk  = '0;
    bus.dispatch_tag = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (grant[i]) begin
        bus.dispatch_op  = bus.dispatch_op  | op_q[i];
        bus.dispatch_vj  = bus.dispatch_vj  | vj_q[i];
        bus.dispatch_vk  = bus.dispatch_vk  | vk_q[i];
        bus.dispatch_tag = bus.dispatch_tag | dest_q[i];
      end
    end
  end

  // Entry state: reset, flush, dispatch release, CDB capture and issue write.
  // Issue only targets a non-busy entry, so it never collides with capture
  // or dispatch of the same entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy     <= '0;
      qj_valid <= '0;
      qk_valid <= '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        op_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        dest_q[i] <= '0;
      end
    end else if (bus.flush) begin
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (dispatch_fire && grant[i]) begin
          busy[i] <= 1'b0;
        end
        if (busy[i] && bus.cdb_active && qj_valid[i] && (qj_q[i] == bus.cdb_tag)) begin
          vj_q[i]     <= bus.cdb_data;
          qj_valid[i] <= 1'b0;
        end
        if (busy[i] && bus.cdb_active && qk_valid[i] && (qk_q[i] == bus.cdb_tag)) begin
          vk_q[i]     <= bus.cdb_data;
          qk_valid[i] <= 1'b0;
        end
        if (issue_fire && free_oh[i]) begin
          busy[i]     <= 1'b1;
          op_q[i]     <= bus.issue_op;
          dest_q[i]   <= bus.issue_dest_tag;
          qj_q[i]     <= bus.issue_qj;
          qk_q[i]     <= bus.issue_qk;
          vj_q[i]     <= j_bypass ? bus.cdb_data : bus.issue_vj;
          vk_q[i]     <= k_bypass ? bus.cdb_data : bus.issue_vk;
          qj_valid[i] <= bus.issue_qj_valid && !j_bypass;
          qk_valid[i] <= bus.issue_qk_valid && !k_bypass;
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed testbench for reservation_station with hand-computed expectations.
module tb_reservation_station;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  reservation_station_if #(.XLEN(32), .TAG_WIDTH(8), .OP_WIDTH(4)) bus ();

  reservation_station #(
    .XLEN(32), .TAG_WIDTH(8), .RS_SIZE(4), .OP_WIDTH(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic [7:0] qj, input logic qjv,
                             input logic [7:0] qk, input logic qkv, input logic [7:0] tag);
    bus.issue_en       = 1'b1;
    bus.issue_op       = op;
    bus.issue_vj       = vj;
    bus.issue_vk       = vk;
    bus.issue_qj       = qj;
    bus.issue_qj_valid = qjv;
    bus.issue_qk       = qk;
    bus.issue_qk_valid = qkv;
    bus.issue_dest_tag = tag;
  endtask

  task automatic drive_cdb(input logic [7:0] tag, input logic [31:0] data);
    bus.cdb_active = 1'b1;
    bus.cdb_tag    = tag;
    bus.cdb_data   = data;
  endtask

  task automatic idle();
    bus.issue_en   = 1'b0;
    bus.cdb_active = 1'b0;
    bus.flush      = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.issue_en = 1'b0; bus.issue_op = '0; bus.issue_vj = '0; bus.issue_vk = '0;
    bus.issue_qj = '0; bus.issue_qk = '0; bus.issue_qj_valid = 1'b0;
    bus.issue_qk_valid = 1'b0; bus.issue_dest_tag = '0;
    bus.cdb_active = 1'b0; bus.cdb_data = '0; bus.cdb_tag = '0;
    bus.flush = 1'b0; bus.dispatch_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;

    // Reset state
    check("rst_full", bus.full, 0);
    check("rst_valid", bus.dispatch_valid, 0);
    check("rst_op", bus.dispatch_op, 0);
    check("rst_vj", bus.dispatch_vj, 0);
    check("rst_vk", bus.dispatch_vk, 0);
    check("rst_tag", bus.dispatch_tag, 0);

    // Ready operands: one-cycle issue-to-dispatch
    drive_issue(4'd3, 32'd5, 32'd7, 8'd0, 1'b0, 8'd0, 1'b0, 8'd2);
    tick(); idle();
    check("t1_valid", bus.dispatch_valid, 1);
    check("t1_op", bus.dispatch_op, 3);
    check("t1_vj", bus.dispatch_vj, 5);
    check("t1_vk", bus.dispatch_vk, 7);
    check("t1_tag", bus.dispatch_tag, 2);
    tick();
    check("t1_drained", bus.dispatch_valid, 0);

    // qj pending, satisfied by a later CDB broadcast
    drive_issue(4'd1, 32'hDEAD, 32'd1, 8'd9, 1'b1, 8'd0, 1'b0, 8'd4);
    tick(); idle();
    check("t2_wait0", bus.dispatch_valid, 0);
    tick();
    check("t2_wait1", bus.dispatch_valid, 0);
    drive_cdb(8'd9, 32'h20);
    #1;
    check("t2_wait_bcast", bus.dispatch_valid, 0);
    tick(); idle();
    check("t2_valid", bus.dispatch_valid, 1);
    check("t2_vj", bus.dispatch_vj, 32'h20);
    check("t2_vk", bus.dispatch_vk, 1);
    check("t2_tag", bus.dispatch_tag, 4);
    tick();
    check("t2_drained", bus.dispatch_valid, 0);

    // Issue-cycle CDB bypass on qk
    drive_issue(4'd2, 32'h11, 32'h0, 8'd0, 1'b0, 8'd6, 1'b1, 8'd5);
    drive_cdb(8'd6, 32'hAB);
    tick(); idle();
    check("t3_valid", bus.dispatch_valid, 1);
    check("t3_vk", bus.dispatch_vk, 32'hAB);
    check("t3_vj", bus.dispatch_vj, 32'h11);
    check("t3_tag", bus.dispatch_tag, 5);
    tick();
    check("t3_drained", bus.dispatch_valid, 0);

    // Fill all entries waiting on tag 1, drop an extra issue, release in order
    bus.dispatch_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t4_not_full", bus.full, 0);
      drive_issue(4'd7, 32'h0, 32'(i), 8'd1, 1'b1, 8'd0, 1'b0, 8'(10 + i));
      tick();
    end
    idle();
    check("t4_full", bus.full, 1);
    check("t4_none_ready", bus.dispatch_valid, 0);
    drive_issue(4'd8, 32'h1, 32'h2, 8'd0, 1'b0, 8'd0, 1'b0, 8'd20);
    tick(); idle();
    check("t4_drop_full", bus.full, 1);
    check("t4_drop_valid", bus.dispatch_valid, 0);
    bus.dispatch_ready = 1'b1;
    drive_cdb(8'd1, 32'h55);
    tick(); idle();
    check("t4_full_pre", bus.full, 1);
    check("t4_vj", bus.dispatch_vj, 32'h55);
    for (int i = 0; i < 4; i++) begin
      check("t4_order_valid", bus.dispatch_valid, 1);
      check("t4_order_tag", bus.dispatch_tag, 10 + i);
      check("t4_order_vk", bus.dispatch_vk, i);
      tick();
      check("t4_full_after", bus.full, 0);
    end
    check("t4_drained", bus.dispatch_valid, 0);

    // Backpressure: entries 1 and 3 ready, held on entry 1
    bus.dispatch_ready = 1'b0;
    drive_issue(4'd1, 32'h0, 32'h0, 8'd30, 1'b1, 8'd0, 1'b0, 8'd20); tick();
    drive_issue(4'd2, 32'hA1, 32'hB1, 8'd0, 1'b0, 8'd0, 1'b0, 8'd21); tick();
    drive_issue(4'd3, 32'h0, 32'h0, 8'd30, 1'b1, 8'd0, 1'b0, 8'd22); tick();
    drive_issue(4'd4, 32'hA3, 32'hB3, 8'd0, 1'b0, 8'd0, 1'b0, 8'd23); tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", bus.dispatch_valid, 1);
      check("t5_hold_tag", bus.dispatch_tag, 21);
      tick();
    end
    check("t5_hold_vj", bus.dispatch_vj, 32'hA1);
    bus.dispatch_ready = 1'b1;
    tick();
    check("t5_second_tag", bus.dispatch_tag, 23);
    check("t5_second_op", bus.dispatch_op, 4);
    tick();
    check("t5_drained", bus.dispatch_valid, 0);
    check("t5_partial_full", bus.full, 0);

    // Reset mid-operation discards the two still-pending entries
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive_cdb(8'd30, 32'h99);
    tick(); idle();
    check("t6_reset_valid", bus.dispatch_valid, 0);
    check("t6_reset_tag", bus.dispatch_tag, 0);

    // Flush overrides a simultaneous issue and dispatch handshake
    bus.dispatch_ready = 1'b0;
    drive_issue(4'd5, 32'h1, 32'h2, 8'd0, 1'b0, 8'd0, 1'b0, 8'd40); tick();
    drive_issue(4'd5, 32'h0, 32'h0, 8'd50, 1'b1, 8'd0, 1'b0, 8'd41); tick();
    drive_issue(4'd5, 32'h0, 32'h0, 8'd0, 1'b0, 8'd50, 1'b1, 8'd42); tick();
    idle();
    check("t7_pre_tag", bus.dispatch_tag, 40);
    bus.dispatch_ready = 1'b1;
    bus.flush = 1'b1;
    drive_issue(4'd6, 32'h3, 32'h4, 8'd0, 1'b0, 8'd0, 1'b0, 8'd43);
    tick(); idle();
    check("t7_flush_full", bus.full, 0);
    check("t7_flush_valid", bus.dispatch_valid, 0);
    drive_cdb(8'd50, 32'h77);
    tick(); idle();
    check("t7_no_survivor", bus.dispatch_valid, 0);
    drive_issue(4'd9, 32'h5, 32'h6, 8'd0, 1'b0, 8'd0, 1'b0, 8'd44);
    tick(); idle();
    check("t7_reissue_valid", bus.dispatch_valid, 1);
    check("t7_reissue_tag", bus.dispatch_tag, 44);
    tick();
    check("t7_drained", bus.dispatch_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
